// File: rtl/dut_mul_acc_pipe.sv
// Pipelined signed x unsigned multiply-accumulate with per-frame
// saturation, first/last framing and clock-enable stall.
module dut_mul_acc_pipe #(
    parameter int din0_WIDTH = 23,
    parameter int din1_WIDTH = 17,
    parameter int dout_WIDTH = 48,
    parameter int NUM_STAGE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  first,
    input  logic                  last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int DW = dout_WIDTH;

    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_prod;

    logic [NUM_STAGE-1:0] r_v;
    logic [NUM_STAGE-1:0] r_f;
    logic [NUM_STAGE-1:0] r_l;
    logic [PW-1:0]        r_p [NUM_STAGE];

    logic signed [DW-1:0] r_acc;
    logic                 r_fsat;
    logic [DW-1:0]        r_dout;
    logic                 r_sat;
    logic                 r_ovalid;

    logic                 w_lv;
    logic                 w_lf;
    logic                 w_ll;
    logic signed [PW-1:0] w_lp;
    logic signed [DW:0]   w_base;
    logic signed [DW:0]   w_pe;
    logic signed [DW:0]   w_sum;
    logic                 w_ovf;
    logic                 w_unf;
    logic                 w_fsat;
    logic signed [DW-1:0] w_clamp;

    // Both operands widened to the exact product width; din1 is zero-extended.
    assign w_a    = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
    assign w_b    = {{din0_WIDTH{1'b0}}, din1};
    assign w_prod = w_a * w_b;

    // Valid bits: cleared by reset, shifted only while ce is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
        end else if (ce) begin
            r_v[0] <= in_valid;
            for (int s = 1; s < NUM_STAGE; s++) begin
                r_v[s] <= r_v[s-1];
            end
        end
    end

    // Product and frame markers travel alongside the valid bits.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_p[0] <= w_prod;
            r_f[0] <= first;
            r_l[0] <= last;
            for (int s = 1; s < NUM_STAGE; s++) begin
                r_p[s] <= r_p[s-1];
                r_f[s] <= r_f[s-1];
                r_l[s] <= r_l[s-1];
            end
        end
    end

    assign w_lv = r_v[NUM_STAGE-1];
    assign w_lf = r_f[NUM_STAGE-1];
    assign w_ll = r_l[NUM_STAGE-1];
    assign w_lp = r_p[NUM_STAGE-1];

    // acc is already zero after a last beat, so only first forces base to 0.
    assign w_base = w_lf ? '0 : (DW+1)'(r_acc);
    assign w_pe   = (DW+1)'(w_lp);
    assign w_sum  = w_base + w_pe;
    assign w_ovf  = ~w_sum[DW] & w_sum[DW-1];
    assign w_unf  = w_sum[DW] & ~w_sum[DW-1];
    assign w_fsat = (~w_lf & r_fsat) | w_ovf | w_unf;

    // Clamp the extended sum back into the signed output range.
    always_comb begin
        w_clamp = w_sum[DW-1:0];
        if (w_ovf) begin
            w_clamp = SMAX;
        end else if (w_unf) begin
            w_clamp = SMIN;
        end
    end

    // Accumulate beats; on last emit the sum and clear for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_fsat   <= 1'b0;
            r_dout   <= '0;
            r_sat    <= 1'b0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            if (ce && w_lv) begin
                if (w_ll) begin
                    r_dout   <= w_clamp;
                    r_sat    <= w_fsat;
                    r_ovalid <= 1'b1;
                    r_acc    <= '0;
                    r_fsat   <= 1'b0;
                end else begin
                    r_acc    <= w_clamp;
                    r_fsat   <= w_fsat;
                end
            end
        end
    end

    assign out_valid = r_ovalid;
    assign dout      = r_dout;
    assign sat       = r_sat;

endmodule

// File: tb/tb_dut_mul_acc_pipe.sv
// Directed bench for dut_mul_acc_pipe: a 48-bit and a 40-bit instance
// share stimulus; pulses are captured and compared with hand values.
module tb_dut_mul_acc_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               first;
    logic               last;
    logic [22:0]        din0;
    logic [16:0]        din1;

    logic               a_ov;
    logic signed [47:0] a_dout;
    logic               a_sat;
    logic               b_ov;
    logic signed [39:0] b_dout;
    logic               b_sat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        longint d;
        logic   s;
        int     c;
    } res_t;

    typedef struct {
        int     d0;
        int     d1;
        longint exp;
    } vec_t;

    res_t qa[$];
    res_t qb[$];
    vec_t tbl[7];

    dut_mul_acc_pipe #(
        .din0_WIDTH(23), .din1_WIDTH(17), .dout_WIDTH(48), .NUM_STAGE(2)
    ) u_a (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .first(first), .last(last), .din0(din0), .din1(din1),
        .out_valid(a_ov), .dout(a_dout), .sat(a_sat)
    );

    dut_mul_acc_pipe #(
        .din0_WIDTH(23), .din1_WIDTH(17), .dout_WIDTH(40), .NUM_STAGE(2)
    ) u_b (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .first(first), .last(last), .din0(din0), .din1(din1),
        .out_valid(b_ov), .dout(b_dout), .sat(b_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_ov === 1'b1) qa.push_back('{longint'(a_dout), a_sat, cyc});
        if (b_ov === 1'b1) qb.push_back('{longint'(b_dout), b_sat, cyc});
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1);
    end

    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, act, exp);
        end
    endtask

    task automatic drive(input int d0, input int d1, input logic f,
                         input logic l, input logic v, input logic c);
        @(negedge clk);
        ce       = c;
        in_valid = v;
        first    = f;
        last     = l;
        din0     = d0[22:0];
        din1     = d1[16:0];
    endtask

    task automatic beat(input int d0, input int d1, input logic f,
                        input logic l, output int k);
        drive(d0, d1, f, l, 1'b1, 1'b1);
        k = cyc + 1;
    endtask

    task automatic stall(input int n);
        repeat (n) drive(99, 99, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic flush();
        repeat (8) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
    endtask

    task automatic expa(input string n, input longint ed, input longint es,
                        input int k, input int lat, output int c);
        res_t r;
        c = 0;
        if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s.a pulse got=0 want=1", n);
        end else begin
            r = qa.pop_front();
            c = r.c;
            chk({n, ".a.dout"}, r.d, ed);
            chk({n, ".a.sat"}, longint'(r.s), es);
            if (lat >= 0) chk({n, ".a.lat"}, longint'(r.c - k), longint'(lat));
        end
    endtask

    task automatic expb(input string n, input longint ed, input longint es);
        res_t r;
        if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s.b pulse got=0 want=1", n);
        end else begin
            r = qb.pop_front();
            chk({n, ".b.dout"}, r.d, ed);
            chk({n, ".b.sat"}, longint'(r.s), es);
        end
    endtask

    task automatic chk_empty(input string n);
        chk({n, ".a.extra"}, longint'(qa.size()), 0);
        chk({n, ".b.extra"}, longint'(qb.size()), 0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        int k;
        int k4;
        int c1;
        int c2;

        tbl[0] = '{-3, 5, -15};
        tbl[1] = '{0, 131071, 0};
        tbl[2] = '{7, 0, 0};
        tbl[3] = '{-1, 1, -1};
        tbl[4] = '{1, 131071, 131071};
        tbl[5] = '{4194303, 131071, 64'sd549751488513};
        tbl[6] = '{-4194304, 131071, -64'sd549751619584};

        reset    = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        first    = 1'b0;
        last     = 1'b0;
        din0     = '0;
        din1     = '0;

        // reset with random inputs
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ce       = 1'($urandom);
            in_valid = 1'($urandom);
            first    = 1'($urandom);
            last     = 1'($urandom);
            din0     = 23'($urandom);
            din1     = 17'($urandom);
            @(negedge clk);
            #1;
            chk($sformatf("rst%0d.ov", i), longint'(a_ov), 0);
            chk($sformatf("rst%0d.dout", i), longint'(a_dout), 0);
            chk($sformatf("rst%0d.sat", i), longint'(a_sat), 0);
        end
        reset    = 1'b0;
        ce       = 1'b1;
        in_valid = 1'b0;
        flush();
        chk_empty("rst");

        // single-product frames from the table
        for (int i = 0; i < 7; i++) begin
            beat(tbl[i].d0, tbl[i].d1, 1'b1, 1'b1, k);
            flush();
            expa($sformatf("vec%0d", i), tbl[i].exp, 0, k, 2, c1);
            expb($sformatf("vec%0d", i), tbl[i].exp, 0);
            chk_empty($sformatf("vec%0d", i));
        end

        // four beats with an idle gap
        beat(1000, 7, 1'b1, 1'b0, k);
        beat(-2000, 7, 1'b0, 1'b0, k);
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(3, 100000, 1'b0, 1'b0, k);
        beat(-1, 131071, 1'b0, 1'b1, k4);
        flush();
        expa("gap", 161929, 0, k4, 2, c1);
        expb("gap", 161929, 0);
        chk_empty("gap");
        chk("hold.dout", longint'(a_dout), 161929);

        // same frame with ce stalls mid-frame and at the output
        beat(1000, 7, 1'b1, 1'b0, k);
        beat(-2000, 7, 1'b0, 1'b0, k);
        stall(2);
        beat(3, 100000, 1'b0, 1'b0, k);
        beat(-1, 131071, 1'b0, 1'b1, k4);
        stall(2);
        flush();
        expa("stall", 161929, 0, k4, 4, c1);
        expb("stall", 161929, 0);
        chk_empty("stall");

        // back-to-back frames
        beat(2, 3, 1'b1, 1'b1, k);
        beat(-4, 1, 1'b1, 1'b0, k);
        beat(-4, 1, 1'b0, 1'b1, k4);
        flush();
        expa("b2b0", 6, 0, k, -1, c1);
        expa("b2b1", -8, 0, k4, 2, c2);
        chk("b2b.gap", longint'(c2 - c1), 2);
        expb("b2b0", 6, 0);
        expb("b2b1", -8, 0);
        chk_empty("b2b");

        beat(2, 3, 1'b1, 1'b1, k);
        beat(5, 1, 1'b1, 1'b1, k4);
        flush();
        expa("bb0", 6, 0, k, 2, c1);
        expa("bb1", 5, 0, k4, 2, c2);
        chk("bb.gap", longint'(c2 - c1), 1);
        expb("bb0", 6, 0);
        expb("bb1", 5, 0);
        chk_empty("bb");

        // beat without first after a completed frame starts from zero
        beat(10, 10, 1'b0, 1'b1, k);
        flush();
        expa("nofirst", 100, 0, k, 2, c1);
        expb("nofirst", 100, 0);
        chk_empty("nofirst");

        // negative saturation on the 40-bit instance
        beat(-4194304, 131071, 1'b1, 1'b0, k);
        beat(-4194304, 131071, 1'b0, 1'b1, k4);
        flush();
        expa("satn", -64'sd1099503239168, 0, k4, 2, c1);
        expb("satn", -64'sd549755813888, 1);
        chk_empty("satn");

        beat(1, 1, 1'b1, 1'b1, k);
        flush();
        expa("after", 1, 0, k, 2, c1);
        expb("after", 1, 0);
        chk_empty("after");

        // positive clamp, then a later beat adds to the clamped value
        beat(4194303, 131071, 1'b1, 1'b0, k);
        beat(4194303, 131071, 1'b0, 1'b0, k);
        beat(-4194304, 131071, 1'b0, 1'b1, k4);
        flush();
        expa("satp", 64'sd549751357442, 0, k4, 2, c1);
        expb("satp", 4194303, 1);
        chk_empty("satp");

        // reset mid-frame discards in-flight beats
        beat(5, 5, 1'b1, 1'b0, k);
        beat(5, 5, 1'b0, 1'b1, k);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        flush();
        chk_empty("midrst");
        chk("midrst.dout", longint'(a_dout), 0);
        chk("midrst.sat", longint'(b_sat), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
